// File: rtl/match_sequencer.sv
// Pong match sequencer: start synchronizer, game-tick prescaler, serve countdown,
// score keeping and SSD digit codes. All outputs are registered.
module match_sequencer #(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_DELAY = 50,
  parameter int TICK_W      = 19
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic       game_tick,
  output logic       ball_enable,
  output logic       serve_side,
  output logic [1:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner,
  output logic [3:0] ssd3,
  output logic [3:0] ssd2,
  output logic [3:0] ssd1,
  output logic [3:0] ssd0
);

  typedef enum logic [1:0] {
    QI      = 2'b00,
    QGAME_1 = 2'b01,
    QGAME_2 = 2'b10,
    QDONE   = 2'b11
  } state_t;

  localparam logic [7:0] DELAY = 8'(SERVE_DELAY);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);

  state_t            st, st_n;
  logic              s1, s2, s2_d;
  logic              start_rise;
  logic [TICK_W-1:0] cnt;
  logic [7:0]        countdown, cd_n;
  logic [3:0]        p1_n, p2_n, p1_inc, p2_inc;
  logic [1:0]        win_n;
  logic              ball_n, serve_n;

  assign start_rise = s2 & ~s2_d;
  assign state      = st;
  assign p1_inc     = p1_score + 4'd1;
  assign p2_inc     = p2_score + 4'd1;

  function automatic logic [3:0] digit_hi(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'hF;
  endfunction

  function automatic logic [3:0] digit_lo(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

  always_comb begin
    st_n    = st;
    p1_n    = p1_score;
    p2_n    = p2_score;
    win_n   = winner;
    cd_n    = countdown;
    ball_n  = ball_enable;
    serve_n = serve_side;
    case (st)
      QI: begin
        p1_n   = 4'd0;
        p2_n   = 4'd0;
        win_n  = 2'b00;
        ball_n = 1'b0;
        if (start_rise) begin
          st_n    = QGAME_1;
          serve_n = 1'b0;
          cd_n    = DELAY;
        end
      end
      QGAME_1, QGAME_2: begin
        if (!s2) begin
          st_n   = QI;
          p1_n   = 4'd0;
          p2_n   = 4'd0;
          win_n  = 2'b00;
          ball_n = 1'b0;
        end else if (ball_enable && (p1_point || p2_point)) begin
          ball_n = 1'b0;
          if (p1_point && p2_point) begin
            cd_n = DELAY;
          end else if (p1_point) begin
            p1_n = p1_inc;
            if (p1_inc == WIN) begin
              st_n  = QDONE;
              win_n = 2'b01;
            end else begin
              st_n    = QGAME_2;
              serve_n = 1'b1;
              cd_n    = DELAY;
            end
          end else begin
            p2_n = p2_inc;
            if (p2_inc == WIN) begin
              st_n  = QDONE;
              win_n = 2'b10;
            end else begin
              st_n    = QGAME_1;
              serve_n = 1'b0;
              cd_n    = DELAY;
            end
          end
        end else begin
          if (game_tick && countdown != 8'd0) cd_n = countdown - 8'd1;
          ball_n = (countdown == 8'd0);
        end
      end
      QDONE: begin
        ball_n = 1'b0;
        if (!s2) begin
          st_n  = QI;
          p1_n  = 4'd0;
          p2_n  = 4'd0;
          win_n = 2'b00;
        end
      end
      default: st_n = QI;
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      s2_d        <= 1'b0;
      cnt         <= '0;
      game_tick   <= 1'b0;
      st          <= QI;
      countdown   <= 8'd0;
      p1_score    <= 4'd0;
      p2_score    <= 4'd0;
      winner      <= 2'b00;
      ball_enable <= 1'b0;
      serve_side  <= 1'b0;
      ssd3        <= 4'hF;
      ssd2        <= 4'hF;
      ssd1        <= 4'hF;
      ssd0        <= 4'hF;
    end else begin
      s1          <= start;
      s2          <= s1;
      s2_d        <= s2;
      cnt         <= cnt + 1'b1;
      game_tick   <= (cnt == {TICK_W{1'b1}});
      st          <= st_n;
      countdown   <= cd_n;
      p1_score    <= p1_n;
      p2_score    <= p2_n;
      winner      <= win_n;
      ball_enable <= ball_n;
      serve_side  <= serve_n;
      // Digits follow the next-state scores so they line up with the score outputs.
      if (st_n == QI) begin
        ssd3 <= 4'hF;
        ssd2 <= 4'hF;
        ssd1 <= 4'hF;
        ssd0 <= 4'hF;
      end else begin
        ssd3 <= digit_hi(p1_n);
        ssd2 <= digit_lo(p1_n);
        ssd1 <= digit_hi(p2_n);
        ssd0 <= digit_lo(p2_n);
      end
    end
  end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with a score/state/SSD scoreboard.
// Valid/ready does not apply here: point inputs are single-cycle pulses.
module tb_match_sequencer;

  localparam int WIN = 10;

  logic       board_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       p1_point = 1'b0;
  logic       p2_point = 1'b0;
  logic       game_tick, ball_enable, serve_side;
  logic [1:0] state, winner;
  logic [3:0] p1_score, p2_score, ssd3, ssd2, ssd1, ssd0;

  match_sequencer #(.WIN_SCORE(WIN), .SERVE_DELAY(3), .TICK_W(2)) dut (
    .board_clk(board_clk), .reset(reset), .start(start),
    .p1_point(p1_point), .p2_point(p2_point),
    .game_tick(game_tick), .ball_enable(ball_enable), .serve_side(serve_side),
    .state(state), .p1_score(p1_score), .p2_score(p2_score), .winner(winner),
    .ssd3(ssd3), .ssd2(ssd2), .ssd1(ssd1), .ssd0(ssd0)
  );

  always #5 board_clk = ~board_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [27:0] exp_q[$];
  logic [1:0]  m_state = 2'b00;
  logic [3:0]  m_p1 = 4'd0;
  logic [3:0]  m_p2 = 4'd0;
  logic [1:0]  m_win = 2'b00;
  logic        m_serve = 1'b0;
  int          t;

  function automatic logic [27:0] model_snap();
    logic [15:0] ssd;
    if (m_state == 2'b00) ssd = 16'hFFFF;
    else ssd = {(m_p1 > 4'd9) ? 4'h1 : 4'hF, m_p1 % 4'd10,
                (m_p2 > 4'd9) ? 4'h1 : 4'hF, m_p2 % 4'd10};
    return {m_state, m_p1, m_p2, m_win, ssd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge board_clk);
    #1;
  endtask

  task automatic push_exp();
    exp_q.push_back(model_snap());
  endtask

  task automatic check_exp(input string tag);
    logic [27:0] e;
    e = exp_q.pop_front();
    chk(tag, {4'b0, state, p1_score, p2_score, winner, ssd3, ssd2, ssd1, ssd0}, {4'b0, e});
  endtask

  task automatic model_idle();
    m_state = 2'b00;
    m_p1    = 4'd0;
    m_p2    = 4'd0;
    m_win   = 2'b00;
  endtask

  // One-cycle point pulse; live says whether the rally is expected to be live.
  task automatic point(input logic a, input logic b, input string tag, input logic live);
    if (live && !(a && b)) begin
      if (a) begin
        m_p1 = m_p1 + 4'd1;
        if (m_p1 == 4'(WIN)) begin m_state = 2'b11; m_win = 2'b01; end
        else begin m_state = 2'b10; m_serve = 1'b1; end
      end else begin
        m_p2 = m_p2 + 4'd1;
        if (m_p2 == 4'(WIN)) begin m_state = 2'b11; m_win = 2'b10; end
        else begin m_state = 2'b01; m_serve = 1'b0; end
      end
    end
    push_exp();
    p1_point = a;
    p2_point = b;
    step();
    p1_point = 1'b0;
    p2_point = 1'b0;
    check_exp(tag);
    chk({tag, "_ball"}, ball_enable, 1'b0);
    chk({tag, "_serve"}, serve_side, m_serve);
  endtask

  task automatic wait_ball(output int ticks);
    ticks = 0;
    for (int i = 0; i < 40 && !ball_enable; i++) begin
      if (game_tick) ticks++;
      step();
    end
    chk("ball_enable_rise", ball_enable, 1'b1);
  endtask

  task automatic start_match(input string tag);
    start = 1'b1;
    step();
    chk({tag, "_sync1"}, state, 2'b00);
    step();
    chk({tag, "_sync2"}, state, 2'b00);
    step();
    m_state = 2'b01;
    m_serve = 1'b0;
    push_exp();
    check_exp(tag);
    chk({tag, "_ball"}, ball_enable, 1'b0);
  endtask

  initial begin
    int first;
    step();
    step();
    push_exp();
    check_exp("reset_snap");
    chk("reset_ball", ball_enable, 1'b0);
    chk("reset_tick", game_tick, 1'b0);
    chk("reset_serve", serve_side, 1'b0);

    reset = 1'b0;
    t = 0;
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (game_tick) begin
        t++;
        if (first == 0) first = i;
      end
    end
    chk("tick_count", t, 5);
    chk("tick_first", first, 4);
    push_exp();
    check_exp("idle_hold");

    start_match("enter_game1");
    wait_ball(t);
    chk("serve_ticks", t, 3);

    point(1'b1, 1'b0, "p1_point", 1'b1);
    point(1'b1, 1'b0, "p1_ignored", 1'b0);
    wait_ball(t);
    point(1'b1, 1'b1, "replay", 1'b1);
    wait_ball(t);
    chk("replay_ticks", t, 3);

    for (int i = 0; i < 10; i++) begin
      point(1'b0, 1'b1, "p2_run", 1'b1);
      if (m_state != 2'b11) wait_ball(t);
    end
    chk("done_winner", winner, 2'b10);
    point(1'b1, 1'b0, "done_p1_ignored", 1'b0);
    point(1'b0, 1'b1, "done_p2_ignored", 1'b0);

    start = 1'b0;
    step();
    chk("done_hold1", state, 2'b11);
    step();
    chk("done_hold2", state, 2'b11);
    step();
    model_idle();
    push_exp();
    check_exp("done_to_idle");

    start_match("second_match");
    for (int i = 0; i < 5; i++) begin
      wait_ball(t);
      point(1'b1, 1'b0, "p1_build", 1'b1);
    end
    for (int i = 0; i < 7; i++) begin
      wait_ball(t);
      point(1'b0, 1'b1, "p2_build", 1'b1);
    end
    wait_ball(t);
    start = 1'b0;
    step();
    chk("abort_hold1", state, m_state);
    step();
    chk("abort_hold2", state, m_state);
    p1_point = 1'b1;
    step();
    p1_point = 1'b0;
    model_idle();
    push_exp();
    check_exp("abort_priority");
    chk("abort_ball", ball_enable, 1'b0);

    start_match("third_match");
    wait_ball(t);
    point(1'b0, 1'b1, "p2_before_reset", 1'b1);
    wait_ball(t);
    #3;
    reset = 1'b1;
    #1;
    model_idle();
    m_serve = 1'b0;
    push_exp();
    check_exp("async_reset");
    chk("async_reset_ball", ball_enable, 1'b0);
    chk("async_reset_serve", serve_side, 1'b0);
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    push_exp();
    check_exp("post_reset_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
